// File: rtl/hamming74_codec_if.sv
// Hamming(7,4) codec bus: data/error-position stimulus in, codeword and decode results out.
// Latency: none (wires only).
// Backpressure: none; the codec accepts one sample per cycle unconditionally.
interface hamming74_codec_if;
  logic [3:0] data_in;
  logic [2:0] err_pos;
  logic [6:0] codeword_out;
  logic [3:0] data_out;
  logic [2:0] syndrome_out;
  logic       correct;

  // Stimulus side: drives data and error position, observes codec results.
  modport master (
    output data_in, err_pos,
    input  codeword_out, data_out, syndrome_out, correct
  );

  // Codec side.
  modport slave (
    input  data_in, err_pos,
    output codeword_out, data_out, syndrome_out, correct
  );
endinterface

// File: rtl/hamming74_codec.sv
// Hamming(7,4) encoder + single-bit error injection + syndrome decoder with built-in result checker.
// Latency: codeword 1 edge after sampling, corrected data/syndrome 2 edges after sampling.
// Backpressure: none; fully pipelined, one sample per cycle, never stalls.
module hamming74_codec (
  input  logic              clock,
  input  logic              reset,
  hamming74_codec_if.slave  bus
);

  // Codeword positions 1..7 live in bits 0..6: p1 p2 d1 p3 d2 d3 d4.
  function automatic logic [6:0] onehot7(input logic [2:0] pos);
    logic [6:0] mask;
    mask = 7'd0;
    for (int k = 1; k <= 7; k++) begin
      if (pos == 3'(k)) mask[k-1] = 1'b1;
    end
    return mask;
  endfunction

  logic [6:0] w_cw_enc;
  logic [6:0] w_err_mask;
  logic [2:0] w_syndrome;
  logic [6:0] w_cw_fixed;
  logic [3:0] w_data_fixed;

  logic [6:0] r_cw;
  logic [3:0] r_data;
  logic [2:0] r_syndrome;
  logic [3:0] r_dly1;
  logic [3:0] r_dly2;

  // Encode the incoming nibble and build the injected-error mask.
  always_comb begin
    w_cw_enc[0] = bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[3];
    w_cw_enc[1] = bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[3];
    w_cw_enc[2] = bus.data_in[0];
    w_cw_enc[3] = bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[3];
    w_cw_enc[4] = bus.data_in[1];
    w_cw_enc[5] = bus.data_in[2];
    w_cw_enc[6] = bus.data_in[3];
    w_err_mask  = onehot7(bus.err_pos);
  end

  // Syndrome of the registered codeword points at the flipped position; undo it and extract data.
  always_comb begin
    w_syndrome[0] = r_cw[0] ^ r_cw[2] ^ r_cw[4] ^ r_cw[6];
    w_syndrome[1] = r_cw[1] ^ r_cw[2] ^ r_cw[5] ^ r_cw[6];
    w_syndrome[2] = r_cw[3] ^ r_cw[4] ^ r_cw[5] ^ r_cw[6];
    w_cw_fixed    = r_cw ^ onehot7(w_syndrome);
    w_data_fixed  = {w_cw_fixed[6], w_cw_fixed[5], w_cw_fixed[4], w_cw_fixed[2]};
  end

  // Encoder stage: register the (possibly corrupted) codeword.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_cw <= 7'd0;
    else       r_cw <= w_cw_enc ^ w_err_mask;
  end

  // Decoder stage: register syndrome and corrected data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_syndrome <= 3'd0;
      r_data     <= 4'd0;
    end else begin
      r_syndrome <= w_syndrome;
      r_data     <= w_data_fixed;
    end
  end

  // Two-deep delay of the original data so it lines up with the decoder output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dly1 <= 4'd0;
      r_dly2 <= 4'd0;
    end else begin
      r_dly1 <= bus.data_in;
      r_dly2 <= r_dly1;
    end
  end

  assign bus.codeword_out = r_cw;
  assign bus.data_out     = r_data;
  assign bus.syndrome_out = r_syndrome;
  // Both sides clear together on reset, so this reads 1 straight out of reset.
  assign bus.correct      = (r_data == r_dly2);

endmodule

// File: tb/tb_hamming74_codec.sv
// Testbench for hamming74_codec: directed vectors, counting sweep with mid-stream reset, random traffic.
// Reference model builds codewords/syndromes from position-index arithmetic.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_hamming74_codec;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  hamming74_codec_if bus_if ();

  hamming74_codec dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] d;
    logic [2:0] e;
  } samp_t;

  samp_t hist[$];

  // Generic Hamming rule: data fills non-power-of-two positions in order,
  // parity at position p covers every position whose index has bit p set.
  function automatic logic [6:0] model_encode(input logic [3:0] d);
    logic [6:0] cw;
    int         data_pos[4];
    data_pos = '{3, 5, 6, 7};
    cw = 7'd0;
    for (int i = 0; i < 4; i++) cw[data_pos[i]-1] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int k = 1; k <= 7; k++) begin
        if (k != p && (k & p) != 0) cw[p-1] = cw[p-1] ^ cw[k-1];
      end
    end
    return cw;
  endfunction

  function automatic logic [6:0] model_flip(input logic [6:0] cw, input int pos);
    logic [6:0] r;
    r = cw;
    if (pos != 0) r[pos-1] = ~r[pos-1];
    return r;
  endfunction

  // Syndrome = XOR of the indices of all set positions.
  function automatic logic [2:0] model_syndrome(input logic [6:0] cw);
    int s;
    s = 0;
    for (int k = 1; k <= 7; k++) if (cw[k-1]) s = s ^ k;
    return 3'(s);
  endfunction

  function automatic logic [3:0] model_decode(input logic [6:0] cw);
    logic [6:0] c;
    c = model_flip(cw, int'(model_syndrome(cw)));
    return {c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic [6:0] model_channel(input samp_t s);
    return model_flip(model_encode(s.d), int'(s.e));
  endfunction

  task automatic push_sample();
    samp_t s;
    s.d = bus_if.data_in;
    s.e = bus_if.err_pos;
    hist.push_front(s);
    if (hist.size() > 2) void'(hist.pop_back());
  endtask

  task automatic test_reset();
    // Put some non-zero state in the pipeline first.
    bus_if.data_in = 4'hB;
    bus_if.err_pos = 3'd5;
    repeat (3) @(posedge clock);
    #1;
    bus_if.data_in = 4'h6;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus_if.codeword_out !== 7'd0 || bus_if.data_out !== 4'd0 ||
        bus_if.syndrome_out !== 3'd0 || bus_if.correct !== 1'b1) begin
      bad++;
      $display("FAIL reset_async cw=%b data=%b syn=%0d correct=%b required all zero, correct=1",
               bus_if.codeword_out, bus_if.data_out, bus_if.syndrome_out, bus_if.correct);
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      total++;
      if (bus_if.codeword_out !== 7'd0 || bus_if.data_out !== 4'd0 ||
          bus_if.syndrome_out !== 3'd0 || bus_if.correct !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d cw=%b data=%b syn=%0d correct=%b required all zero, correct=1",
                 i, bus_if.codeword_out, bus_if.data_out, bus_if.syndrome_out, bus_if.correct);
      end
    end
    reset = 1'b0;
    hist.delete();
  endtask

  task automatic test_directed();
    logic [3:0] v_d[4];
    logic [2:0] v_e[4];
    logic [6:0] v_cw[4];
    logic [2:0] v_syn[4];
    v_d   = '{4'b1011, 4'b1011, 4'b0000, 4'b1111};
    v_e   = '{3'd0, 3'd3, 3'd7, 3'd0};
    v_cw  = '{7'b1010101, 7'b1010001, 7'b1000000, 7'h7F};
    v_syn = '{3'd0, 3'd3, 3'd7, 3'd0};
    for (int i = 0; i < 4; i++) begin
      bus_if.data_in = v_d[i];
      bus_if.err_pos = v_e[i];
      @(posedge clock);
      #1;
      total++;
      if (bus_if.codeword_out !== v_cw[i]) begin
        bad++;
        $display("FAIL directed_cw vec=%0d got=%b required=%b", i, bus_if.codeword_out, v_cw[i]);
      end
      bus_if.data_in = 4'd0;
      bus_if.err_pos = 3'd0;
      @(posedge clock);
      #1;
      total++;
      if (bus_if.syndrome_out !== v_syn[i]) begin
        bad++;
        $display("FAIL directed_syn vec=%0d got=%0d required=%0d", i, bus_if.syndrome_out, v_syn[i]);
      end
      total++;
      if (bus_if.data_out !== v_d[i]) begin
        bad++;
        $display("FAIL directed_data vec=%0d got=%b required=%b", i, bus_if.data_out, v_d[i]);
      end
      total++;
      if (bus_if.correct !== 1'b1) begin
        bad++;
        $display("FAIL directed_correct vec=%0d got=%b required=1", i, bus_if.correct);
      end
    end
  endtask

  task automatic test_sweep_with_reset();
    logic [3:0] d;
    logic [2:0] e;
    logic [6:0] exp_cw;
    logic [3:0] exp_data;
    logic [2:0] exp_syn;
    d = 4'd0;
    e = 3'b110;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    hist.delete();
    for (int i = 0; i < 180; i++) begin
      if (i == 120) begin
        reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
          if (r > 0) begin
            @(posedge clock);
            #1;
          end else begin
            #1;
          end
          total++;
          if (bus_if.codeword_out !== 7'd0 || bus_if.data_out !== 4'd0 ||
              bus_if.syndrome_out !== 3'd0 || bus_if.correct !== 1'b1) begin
            bad++;
            $display("FAIL midreset r=%0d cw=%b data=%b syn=%0d correct=%b required all zero, correct=1",
                     r, bus_if.codeword_out, bus_if.data_out, bus_if.syndrome_out, bus_if.correct);
          end
        end
        reset = 1'b0;
        hist.delete();
      end
      bus_if.data_in = d;
      bus_if.err_pos = e;
      @(posedge clock);
      #1;
      push_sample();
      exp_cw   = model_channel(hist[0]);
      exp_syn  = (hist.size() > 1) ? hist[1].e : 3'd0;
      exp_data = (hist.size() > 1) ? model_decode(model_channel(hist[1])) : 4'd0;
      total++;
      if (bus_if.codeword_out !== exp_cw) begin
        bad++;
        $display("FAIL sweep_cw i=%0d got=%b required=%b", i, bus_if.codeword_out, exp_cw);
      end
      total++;
      if (bus_if.syndrome_out !== exp_syn) begin
        bad++;
        $display("FAIL sweep_syn i=%0d got=%0d required=%0d", i, bus_if.syndrome_out, exp_syn);
      end
      total++;
      if (bus_if.data_out !== exp_data) begin
        bad++;
        $display("FAIL sweep_data i=%0d got=%b required=%b", i, bus_if.data_out, exp_data);
      end
      total++;
      if (bus_if.correct !== 1'b1) begin
        bad++;
        $display("FAIL sweep_correct i=%0d got=%b required=1", i, bus_if.correct);
      end
      d = d + 4'd1;
      e = e + 3'd1;
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_cw;
    logic [3:0] exp_data;
    logic [2:0] exp_syn;
    for (int i = 0; i < 300; i++) begin
      bus_if.data_in = 4'($urandom_range(15, 0));
      bus_if.err_pos = 3'($urandom_range(7, 0));
      @(posedge clock);
      #1;
      push_sample();
      exp_cw   = model_channel(hist[0]);
      exp_syn  = (hist.size() > 1) ? model_syndrome(model_channel(hist[1])) : 3'd0;
      exp_data = (hist.size() > 1) ? hist[1].d : 4'd0;
      total++;
      if (bus_if.codeword_out !== exp_cw || bus_if.syndrome_out !== exp_syn ||
          bus_if.data_out !== exp_data || bus_if.correct !== 1'b1) begin
        bad++;
        $display("FAIL random i=%0d cw=%b/%b syn=%0d/%0d data=%b/%b correct=%b/1 (got/required)",
                 i, bus_if.codeword_out, exp_cw, bus_if.syndrome_out, exp_syn,
                 bus_if.data_out, exp_data, bus_if.correct);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_if.data_in = 4'd0;
    bus_if.err_pos = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    hist.delete();
    test_reset();
    test_directed();
    test_sweep_with_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming74_codec.md
Name: hamming74_codec

Overview:
Hamming(7,4) encode/decode pair with a single-bit error-injection channel between the two halves.
- The encoder registers a 7-bit codeword from 4 data bits, optionally flipping one codeword bit chosen by a 3-bit error-position input.
- The decoder computes the syndrome, corrects the flipped bit and recovers the 4 data bits.
- A built-in checker compares the recovered data against the delayed original data. The block serves as a self-checking reference for channel/coder experiments.

Parameters:
None. All widths are fixed: 4 data bits, 7 code bits, 3 syndrome bits.

Ports:
- clock  in  1  single clock; all registers update on the rising edge
- reset  in  1  asynchronous, active-high; clears all registers
- data_in  in  4  data bits; data_in[0]=d1 … data_in[3]=d4
- err_pos  in  3  error position; 0 = no error, k = 1..7 flips codeword position k
- codeword_out  out  7  registered (possibly corrupted) codeword; codeword_out[k-1] = position k
- data_out  out  4  registered decoded/corrected data
- syndrome_out  out  3  registered syndrome of the codeword being decoded
- correct  out  1  1 when data_out equals the data_in that produced it

Behaviour:
- Codeword layout, positions 1..7 = p1 p2 d1 p3 d2 d3 d4.
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p3 = d2^d3^d4
- Encoder stage, at each clock edge:
  - codeword_out <= encode(data_in) XOR onehot(err_pos).
  - onehot(0) = 0; onehot(k) sets bit k-1 only.
- Syndrome, computed from codeword_out (c1..c7):
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s3 = c4^c5^c6^c7
  - syndrome = {s3,s2,s1}, which equals the flipped position, or 0 if none.
- Decoder stage, at each clock edge:
  - syndrome_out <= syndrome.
  - data_out <= {c7,c6,c5,c3} after flipping position syndrome (no flip when 0).
- Latency:
  - data_in/err_pos sampled at edge N appear in codeword_out after edge N.
  - The corresponding data_out/syndrome_out appear after edge N+1.
  - Fully pipelined: one new sample per cycle, no stalls, no handshake.
- Checker:
  - A 2-stage delay line of data_in, cleared on reset.
  - correct = (data_out == delayed data_in), combinational from registers.
- Reset, asynchronous and active-high: codeword_out = 0, data_out = 0, syndrome_out = 0, delay line = 0. Therefore correct = 1 during and after reset.
  - Reset mid-stream discards in-flight samples.
  - The first valid output follows 2 edges after reset deasserts.
- Every err_pos value 0..7 with any data_in must yield correct = 1. The code corrects exactly one flipped bit.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Assert reset asynchronously between edges -> all outputs 0 immediately, correct=1; hold 50 cycles -> unchanged.
- data_in=4'b1011, err_pos=0 -> codeword_out=7'b1010101 after 1 edge; syndrome_out=0, data_out=4'b1011, correct=1 after the next edge.
- data_in=4'b1011, err_pos=3 -> codeword_out=7'b1010001; syndrome_out=3'd3, data_out=4'b1011, correct=1.
- data_in=4'b0000, err_pos=7 -> codeword_out=7'b1000000, syndrome_out=7, data_out=0. Separately, data_in=4'b1111, err_pos=0 -> codeword_out=7'h7F, syndrome_out=0.
- Sweep: after reset, data_in counts up from 0 and err_pos counts up from 3'b110, both +1 per cycle with wrap, for at least 128 cycles -> correct=1 on every cycle, and syndrome_out equals the err_pos sampled 2 edges earlier.
- Reset asserted mid-sweep for 3 cycles then released -> outputs 0 while asserted; correct stays 1 throughout; the sweep resumes with 2-edge latency.
